// File: rtl/lsu_pkg.sv
// Shared types and helpers for the sub-word load/store sequencer in front of the word-only LSU.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_e;

    typedef logic [1:0] state_e;
    localparam state_e IDLE  = 2'd0;
    localparam state_e READ  = 2'd1;
    localparam state_e WRITE = 2'd2;
    localparam state_e RESP  = 2'd3;

    // Flags misaligned halves/words, unknown funct3 codes, and unsigned variants used as stores.
    function automatic logic misalign(input logic we, input logic [2:0] op, input logic [1:0] addr_lo);
        logic bad_s;
        bad_s = 1'b1;
        case (op)
            OP_B:    bad_s = 1'b0;
            OP_H:    bad_s = addr_lo[0];
            OP_W:    bad_s = (addr_lo != 2'b00);
            OP_BU:   bad_s = we;
            OP_HU:   bad_s = we | addr_lo[0];
            default: bad_s = 1'b1;
        endcase
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: store merge into a read word and load extract with sign/zero extension.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] st_word,
    output logic [31:0] ld_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[{addr_lo, 3'b000} +: 8];
    assign half_s = word[{addr_lo[1], 4'b0000} +: 16];

    // Store merge: replace the addressed byte or half of the old word, or take the full store word.
    always_comb begin
        st_word = wdata;
        case (op[1:0])
            2'b00: begin
                st_word = word;
                st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                st_word = word;
                st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

    // Load extract: select the addressed lane and extend it to a full word.
    always_comb begin
        ld_word = word;
        case (op)
            OP_B:    ld_word = {{24{byte_s[7]}}, byte_s};
            OP_BU:   ld_word = {24'h000000, byte_s};
            OP_H:    ld_word = {{16{half_s[15]}}, half_s};
            OP_HU:   ld_word = {16'h0000, half_s};
            default: ld_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// MEM-stage sequencer that turns byte/half/word loads and stores into word-only LSU reads and
// full-word writes, using read-modify-write for SB/SH and flagging misaligned or illegal requests.
module lsu_subword_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic              lsu_st_en_o,
    output logic [DATA_W-1:0] lsu_st_data_o,
    input  logic [DATA_W-1:0] lsu_ld_data_i
);

    state_e            state_q;
    state_e            state_d;
    logic              we_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic              err_q;

    logic              accept_s;
    logic              bad_s;
    logic [DATA_W-1:0] st_word_s;
    logic [DATA_W-1:0] ld_word_s;

    assign accept_s = req_valid_i & (state_q == IDLE);
    assign bad_s    = misalign(req_we_i, req_op_i, req_addr_i[1:0]);

    lsu_byte_lane u_lane (
        .word    (word_q),
        .wdata   (wdata_q),
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .st_word (st_word_s),
        .ld_word (ld_word_s)
    );

    // Next-state decode; SB/SH need the old word first, SW goes straight to the write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (bad_s) begin
                        state_d = RESP;
                    end else if (!req_we_i || (req_op_i[1:0] != 2'b10)) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request capture on accept, and old-word capture during READ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            word_q  <= {DATA_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                we_q    <= req_we_i;
                op_q    <= req_op_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                err_q   <= bad_s;
            end
            if (state_q == READ) begin
                word_q <= lsu_ld_data_i;
            end
        end
    end

    // Outputs decoded only from registered state so a reset clears them immediately.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        lsu_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        rsp_valid_o = (state_q == RESP);
        rsp_err_o   = (state_q == RESP) & err_q;
        if (state_q == WRITE) begin
            lsu_st_en_o   = 1'b1;
            lsu_st_data_o = st_word_s;
        end else begin
            lsu_st_en_o   = 1'b0;
            lsu_st_data_o = {DATA_W{1'b0}};
        end
        if ((state_q == RESP) && !err_q && !we_q) begin
            rsp_rdata_o = ld_word_s;
        end else begin
            rsp_rdata_o = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl against a small word-memory model of the LSU.
module tb_lsu_subword_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] lsu_addr;
    logic        lsu_st_en;
    logic [31:0] lsu_st_data;
    logic [31:0] lsu_ld_data;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:127];
    logic        bd_we;
    logic [6:0]  bd_idx;
    logic [31:0] bd_data;
    logic [6:0]  lsu_idx;

    lsu_subword_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy),
        .lsu_addr_o    (lsu_addr),
        .lsu_st_en_o   (lsu_st_en),
        .lsu_st_data_o (lsu_st_data),
        .lsu_ld_data_i (lsu_ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LSU model: DM at 0x2xxx, LEDR 0x7000, HEX 0x7020; the switch region 0x78xx drops writes.
    assign lsu_idx     = {lsu_addr[14:12], lsu_addr[5:2]};
    assign lsu_ld_data = lsu_st_en ? 32'h0 : mem[lsu_idx];

    always @(posedge clk) begin
        if (lsu_st_en) begin
            if (lsu_addr[15:8] != 8'h78) mem[lsu_idx] <= lsu_st_data;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    function automatic logic [6:0] midx(input logic [31:0] a);
        return {a[14:12], a[5:2]};
    endfunction

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        bd_idx  = midx(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    // Issues one request and follows it to its response (latency 0 means no response seen).
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int st_cnt, output logic [31:0] st_seen);
        int w;
        lat = 0; rdata = 32'h0; err = 1'b0; st_cnt = 0; st_seen = 32'h0; w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (lsu_st_en) begin
                st_cnt++;
                st_seen = lsu_st_data;
            end
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if ({rsp_valid, rsp_err, lsu_st_en} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {rsp_valid, rsp_err, lsu_st_en}); end
        vectors++; if ({rsp_rdata, lsu_st_data, lsu_addr} !== 96'h0) begin miscompares++; $display("FAIL reset_data: got %h/%h/%h expected 0", rsp_rdata, lsu_st_data, lsu_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
        logic [31:0] adrs [7] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000, 32'h2003, 32'h2000};
        logic [31:0] exps [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                  32'h8899AABB, 32'hFFFFFF88, 32'h000000BB};
        int lat; logic [31:0] rd; logic er; int sc; logic [31:0] sd;
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, ops[i], adrs[i], 32'hFFFFFFFF, lat, rd, er, sc, sd);
            vectors++; if (rd !== exps[i]) begin miscompares++; $display("FAIL load_data[%0d]: got %h expected %h", i, rd, exps[i]); end
            vectors++; if (lat !== 2) begin miscompares++; $display("FAIL load_latency[%0d]: got %0d expected 2", i, lat); end
            vectors++; if ({er, sc != 0} !== 2'b00) begin miscompares++; $display("FAIL load_err_st[%0d]: err %b stores %0d expected 0/0", i, er, sc); end
        end
    endtask

    task automatic test_sb_rmw();
        int lat; logic [31:0] rd; logic er; int sc; logic [31:0] sd;
        do_req(1'b1, 3'b000, 32'h2002, 32'hFFFFFF55, lat, rd, er, sc, sd);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        vectors++; if (sc !== 1) begin miscompares++; $display("FAIL sb_write_cycles: got %0d expected 1", sc); end
        vectors++; if (sd !== 32'h8855AABB) begin miscompares++; $display("FAIL sb_st_data: got %h expected 8855aabb", sd); end
        vectors++; if ({er, rd} !== 33'h0) begin miscompares++; $display("FAIL sb_rsp: err %b rdata %h expected 0/0", er, rd); end
        do_req(1'b0, 3'b010, 32'h2000, 32'h0, lat, rd, er, sc, sd);
        vectors++; if (rd !== 32'h8855AABB) begin miscompares++; $display("FAIL sb_readback: got %h expected 8855aabb", rd); end
    endtask

    task automatic test_io_stores();
        int lat; logic [31:0] rd; logic er; int sc; logic [31:0] sd;
        do_req(1'b1, 3'b001, 32'h7000, 32'hABCD1234, lat, rd, er, sc, sd);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        vectors++; if (mem[midx(32'h7000)] !== 32'h00001234) begin miscompares++; $display("FAIL sh_ledr: got %h expected 00001234", mem[midx(32'h7000)]); end
        do_req(1'b1, 3'b010, 32'h7020, 32'hDEADBEEF, lat, rd, er, sc, sd);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        vectors++; if (mem[midx(32'h7020)] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_hex: got %h expected deadbeef", mem[midx(32'h7020)]); end
        vectors++; if ({sc, sd} !== {32'd1, 32'hDEADBEEF}) begin miscompares++; $display("FAIL sw_st: stores %0d data %h expected 1/deadbeef", sc, sd); end
        do_req(1'b1, 3'b010, 32'h7800, 32'hCAFEF00D, lat, rd, er, sc, sd);
        vectors++; if ({lat, er} !== {32'd2, 1'b0}) begin miscompares++; $display("FAIL sw_switch: latency %0d err %b expected 2/0", lat, er); end
        vectors++; if (mem[midx(32'h7000)] !== 32'h00001234) begin miscompares++; $display("FAIL sw_switch_dropped: got %h expected 00001234", mem[midx(32'h7000)]); end
    endtask

    task automatic test_misalign();
        logic        wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ops  [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b010};
        logic [31:0] adrs [6] = '{32'h2002, 32'h2001, 32'h2000, 32'h2000, 32'h2000, 32'h2001};
        int lat; logic [31:0] rd; logic er; int sc; logic [31:0] sd;
        for (int i = 0; i < 6; i++) begin
            do_req(wes[i], ops[i], adrs[i], 32'h13579BDF, lat, rd, er, sc, sd);
            vectors++; if ({lat, er} !== {32'd1, 1'b1}) begin miscompares++; $display("FAIL err_rsp[%0d]: latency %0d err %b expected 1/1", i, lat, er); end
            vectors++; if ({sc, rd} !== 64'h0) begin miscompares++; $display("FAIL err_side[%0d]: stores %0d rdata %h expected 0/0", i, sc, rd); end
        end
        vectors++; if (mem[midx(32'h2000)] !== 32'h8855AABB) begin miscompares++; $display("FAIL err_mem: got %h expected 8855aabb", mem[midx(32'h2000)]); end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h2000; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (lsu_st_en !== 1'b1) begin miscompares++; $display("FAIL abort_in_write: st_en %b expected 1", lsu_st_en); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({lsu_st_en, busy, rsp_valid, req_ready} !== 4'b0001) begin miscompares++; $display("FAIL abort_now: en/busy/valid/ready %b expected 0001", {lsu_st_en, busy, rsp_valid, req_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", seen); end
        vectors++; if (mem[midx(32'h2000)] !== 32'h8855AABB) begin miscompares++; $display("FAIL abort_mem: got %h expected 8855aabb", mem[midx(32'h2000)]); end
    endtask

    task automatic test_back_to_back();
        int n; int cyc [2]; logic [31:0] dat [2]; int overlap;
        n = 0; overlap = 0; cyc[0] = 0; cyc[1] = 0; dat[0] = 32'h0; dat[1] = 32'h0;
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h2000; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_op = 3'b000; req_addr = 32'h2001;
        for (int c = 1; c <= 12; c++) begin
            if (busy && req_ready) overlap++;
            if (rsp_valid) begin
                cyc[n] = c; dat[n] = rsp_rdata; n++;
                if (n == 2) break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        vectors++; if ({cyc[0], dat[0]} !== {32'd2, 32'h8855AABB}) begin miscompares++; $display("FAIL b2b_first: cycle %0d data %h expected 2/8855aabb", cyc[0], dat[0]); end
        vectors++; if ({cyc[1], dat[1]} !== {32'd5, 32'hFFFFFFAA}) begin miscompares++; $display("FAIL b2b_second: cycle %0d data %h expected 5/ffffffaa", cyc[1], dat[1]); end
        vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL b2b_ready_while_busy: got %0d cycles expected 0", overlap); end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        bd_we = 1'b0; bd_idx = 7'h0; bd_data = 32'h0;
        test_reset();
        bd_write(32'h2000, 32'h8899AABB);
        bd_write(32'h7000, 32'h00000000);
        bd_write(32'h7020, 32'h00000000);
        test_loads();
        test_sb_rmw();
        test_io_stores();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
